// File: rtl/link_rx_buffer_pkg.sv
// Shared constants for the mesh-link receive buffer and the upstream link pipeline.
// DATA_WIDTH/LINK_LAT here must match the values used by the link pipeline stages.
package link_rx_buffer_pkg;

  localparam int LINK_DATA_WIDTH = 8;
  localparam int LINK_LAT        = 2;
  localparam int LINK_RX_DEPTH   = 8;

  // Occupancy at which stop must be raised so that the stop register delay (1 cycle)
  // plus LINK_LAT in-flight flits still find free slots.
  function automatic int stop_level(input int depth, input int link_lat);
    return depth - link_lat - 1;
  endfunction

endpackage

// File: rtl/link_rx_buffer_fifo.sv
// Synchronous FIFO core: storage array, read/write pointers and occupancy count.
// The caller guarantees push is only asserted when there is room (or a pop frees a slot).
module sync_fifo_core
  import link_rx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int DEPTH      = LINK_RX_DEPTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]         count_o,
  output logic [CW-1:0]         count_next_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !rst) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign count_o      = count_q;
  assign count_next_o = count_d;
  // Masking with empty keeps out_data at zero after reset even though the array is uninitialised.
  assign rd_data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/link_rx_buffer.sv
// Receive end of a mesh link: buffers incoming flits, presents them with valid/ready and
// raises a registered stop early enough that flits already in the link pipeline are never lost.
module link_rx_buffer
  import link_rx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int DEPTH      = LINK_RX_DEPTH,
  parameter int LINK_LAT   = link_rx_buffer_pkg::LINK_LAT,
  parameter int STOP_LVL   = stop_level(DEPTH, LINK_LAT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     link_valid,
  input  logic [DATA_WIDTH-1:0]    link_data,
  output logic                     link_stop,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] count_cur, count_next;
  logic          link_stop_q, link_stop_d;
  logic          overflow_q, overflow_d;

  assign pop  = !fifo_empty && out_ready;
  assign push = link_valid && (!fifo_full || pop);

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .wr_data_i    (link_data),
    .rd_data_o    (out_data),
    .count_o      (count_cur),
    .count_next_o (count_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // A flit arriving while full with no pop is dropped; flag it until reset.
  always_comb begin
    link_stop_d = (count_next >= CW'(STOP_LVL));
    overflow_d  = overflow_q || (link_valid && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_stop_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      link_stop_q <= link_stop_d;
      overflow_q  <= overflow_d;
    end
  end

  assign link_stop = link_stop_q;
  assign overflow  = overflow_q;
  assign out_valid = !fifo_empty;
  assign count     = count_cur;

endmodule
